// File: rtl/score_digit_driver.sv
// Converts a binary score to four BCD digits by double-dabble and maps the VGA pixel position
// onto a 4-digit glyph field. Optional macro SCORE_LEADING_ZERO_BLANK_EN hides leading zeros.
module score_digit_driver #(
    parameter logic [9:0]  X0      = 10'd20,
    parameter logic [9:0]  Y0      = 10'd20,
    parameter int unsigned DIGIT_W = 45,
    parameter int unsigned DIGIT_H = 36
) (
    input  logic        vga_clk,
    input  logic        reset_n,
    input  logic [13:0] value,
    input  logic        load,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic        busy,
    output logic        done,
    output logic [3:0]  digit,
    output logic        digit_on,
    output logic [5:0]  glyph_x,
    output logic [5:0]  glyph_y
);

    localparam logic [10:0] XEnd = 11'(X0) + 11'(4 * DIGIT_W);
    localparam logic [10:0] YEnd = 11'(Y0) + 11'(DIGIT_H);
    localparam logic [9:0]  W1   = 10'(DIGIT_W);
    localparam logic [9:0]  W2   = 10'(2 * DIGIT_W);
    localparam logic [9:0]  W3   = 10'(3 * DIGIT_W);

    typedef enum logic [1:0] {StIdle, StShift, StCommit} state_e;

    state_e      state_q, state_d;
    logic [13:0] bin_q, bin_d;
    logic [15:0] bcd_q, bcd_d, bcd_adj;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] disp_q, disp_d;
    logic        done_d;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            done    <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        done_d  = 1'b0;
        bcd_adj = bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
        end
        unique case (state_q)
            StIdle: begin
                if (load) begin
                    bin_d   = (value > 14'd9999) ? 14'd9999 : value;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                {bcd_d, bin_d} = {bcd_adj[14:0], bin_q, 1'b0};
                cnt_d          = cnt_q + 4'd1;
                if (cnt_q == 4'd13) state_d = StCommit;
            end
            StCommit: begin
                disp_d  = bcd_q;
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy = (state_q != StIdle);

    // Pixel-to-glyph mapping, registered for a fixed one-cycle latency.
    logic       in_field;
    logic [9:0] rx, ry, off;
    logic [1:0] slot;
    logic [3:0] slot_digit;
    logic       on_d;

    always_comb begin
        rx       = DrawX - X0;
        ry       = DrawY - Y0;
        in_field = (DrawX >= X0) && ({1'b0, DrawX} < XEnd) &&
                   (DrawY >= Y0) && ({1'b0, DrawY} < YEnd);
        if (rx < W1) begin
            slot = 2'd0;
            off  = '0;
        end else if (rx < W2) begin
            slot = 2'd1;
            off  = W1;
        end else if (rx < W3) begin
            slot = 2'd2;
            off  = W2;
        end else begin
            slot = 2'd3;
            off  = W3;
        end
        unique case (slot)
            2'd0:    slot_digit = disp_q[15:12];
            2'd1:    slot_digit = disp_q[11:8];
            2'd2:    slot_digit = disp_q[7:4];
            default: slot_digit = disp_q[3:0];
        endcase
    end

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    logic [3:0] lead_blank;
    always_comb begin
        lead_blank[0] = (disp_q[15:12] == 4'd0);
        lead_blank[1] = lead_blank[0] && (disp_q[11:8] == 4'd0);
        lead_blank[2] = lead_blank[1] && (disp_q[7:4] == 4'd0);
        lead_blank[3] = 1'b0;  // ones digit always shown
        on_d          = in_field && !lead_blank[slot];
    end
`else
    assign on_d = in_field;
`endif

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            digit    <= '0;
            digit_on <= 1'b0;
            glyph_x  <= '0;
            glyph_y  <= '0;
        end else if (in_field) begin
            digit    <= slot_digit;
            digit_on <= on_d;
            glyph_x  <= 6'(rx - off);
            glyph_y  <= 6'(ry);
        end else begin
            digit    <= '0;
            digit_on <= 1'b0;
            glyph_x  <= '0;
            glyph_y  <= '0;
        end
    end

endmodule

// File: tb/tb_score_digit_driver.sv
// Directed bench for score_digit_driver: conversion timing, saturation, load blocking, reset
// abort and a table of pixel positions scanned against the expected digits.
module tb_score_digit_driver;

    logic        vga_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] value   = '0;
    logic        load    = 1'b0;
    logic [9:0]  DrawX   = '0;
    logic [9:0]  DrawY   = '0;
    logic        busy, done, digit_on;
    logic [3:0]  digit;
    logic [5:0]  glyph_x, glyph_y;

    int n_pass  = 0;
    int n_total = 0;

    score_digit_driver dut (
        .vga_clk (vga_clk),
        .reset_n (reset_n),
        .value   (value),
        .load    (load),
        .DrawX   (DrawX),
        .DrawY   (DrawY),
        .busy    (busy),
        .done    (done),
        .digit   (digit),
        .digit_on(digit_on),
        .glyph_x (glyph_x),
        .glyph_y (glyph_y)
    );

    always #5 vga_clk = ~vga_clk;

    typedef struct {
        int x;
        int y;
        int slot;   // -1 means outside the field
        int gx;
        int gy;
    } pix_t;

    pix_t pix_tbl[11];

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Applies every geometry vector and compares against the expected display d0..d3.
    task automatic scan(input string tag, input int d0, input int d1, input int d2, input int d3);
        int d[4];
        bit blank[4];
        int exp_on, exp_dig, exp_gx, exp_gy;
        d = '{d0, d1, d2, d3};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
        blank[0] = (d0 == 0);
        blank[1] = blank[0] && (d1 == 0);
        blank[2] = blank[1] && (d2 == 0);
`else
        blank[0] = 1'b0;
        blank[1] = 1'b0;
        blank[2] = 1'b0;
`endif
        blank[3] = 1'b0;
        foreach (pix_tbl[i]) begin
            DrawX = 10'(pix_tbl[i].x);
            DrawY = 10'(pix_tbl[i].y);
            @(posedge vga_clk);
            #1;
            if (pix_tbl[i].slot < 0) begin
                exp_on = 0; exp_dig = 0; exp_gx = 0; exp_gy = 0;
            end else begin
                exp_on  = blank[pix_tbl[i].slot] ? 0 : 1;
                exp_dig = d[pix_tbl[i].slot];
                exp_gx  = pix_tbl[i].gx;
                exp_gy  = pix_tbl[i].gy;
            end
            check($sformatf("%s pix%0d digit_on", tag, i), int'(digit_on), exp_on);
            check($sformatf("%s pix%0d digit", tag, i), int'(digit), exp_dig);
            check($sformatf("%s pix%0d glyph_x", tag, i), int'(glyph_x), exp_gx);
            check($sformatf("%s pix%0d glyph_y", tag, i), int'(glyph_y), exp_gy);
        end
    endtask

    // Pulses load and expects done on the 16th edge counting the load edge as the first.
    // inject_at > 0 drives a second load (value 7) while the conversion is running.
    task automatic convert(input string tag, input int v, input int inject_at);
        int first_done = 0;
        int pulses     = 0;
        value = 14'(v);
        load  = 1'b1;
        @(posedge vga_clk);
        #1;
        load = 1'b0;
        check({tag, " busy after load"}, int'(busy), 1);
        check({tag, " done after load"}, int'(done), 0);
        for (int k = 2; k <= 24; k++) begin
            @(posedge vga_clk);
            #1;
            if (done) begin
                pulses++;
                if (first_done == 0) first_done = k;
            end
            if (load) load = 1'b0;
            if (k == inject_at) begin
                value = 14'd7;
                load  = 1'b1;
            end
        end
        check({tag, " done edge"}, first_done, 16);
        check({tag, " done pulses"}, pulses, 1);
        check({tag, " busy idle"}, int'(busy), 0);
    endtask

    initial begin
        pix_tbl[0]  = '{x: 65,  y: 20, slot: 1,  gx: 0,  gy: 0};
        pix_tbl[1]  = '{x: 199, y: 20, slot: 3,  gx: 44, gy: 0};
        pix_tbl[2]  = '{x: 200, y: 20, slot: -1, gx: 0,  gy: 0};
        pix_tbl[3]  = '{x: 20,  y: 20, slot: 0,  gx: 0,  gy: 0};
        pix_tbl[4]  = '{x: 19,  y: 30, slot: -1, gx: 0,  gy: 0};
        pix_tbl[5]  = '{x: 64,  y: 55, slot: 0,  gx: 44, gy: 35};
        pix_tbl[6]  = '{x: 110, y: 40, slot: 2,  gx: 0,  gy: 20};
        pix_tbl[7]  = '{x: 154, y: 25, slot: 2,  gx: 44, gy: 5};
        pix_tbl[8]  = '{x: 100, y: 56, slot: -1, gx: 0,  gy: 0};
        pix_tbl[9]  = '{x: 100, y: 19, slot: -1, gx: 0,  gy: 0};
        pix_tbl[10] = '{x: 160, y: 35, slot: 3,  gx: 5,  gy: 15};

        DrawX = 10'd65;
        DrawY = 10'd20;
        repeat (3) @(posedge vga_clk);
        #1;
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset digit_on", int'(digit_on), 0);
        check("reset glyph_x", int'(glyph_x), 0);
        reset_n = 1'b1;
        scan("post-reset", 0, 0, 0, 0);

        convert("v1234", 1234, 0);
        scan("v1234", 1, 2, 3, 4);

        convert("v16383", 16383, 0);
        scan("v16383", 9, 9, 9, 9);

        convert("v50", 50, 0);
        scan("v50", 0, 0, 5, 0);

        convert("v8888+load7", 8888, 5);
        scan("v8888", 8, 8, 8, 8);

        // Abort a conversion of 1234 after seven shift steps.
        value = 14'd1234;
        load  = 1'b1;
        @(posedge vga_clk);
        #1;
        load = 1'b0;
        repeat (7) @(posedge vga_clk);
        #1;
        check("abort busy before reset", int'(busy), 1);
        reset_n = 1'b0;
        #2;
        check("abort busy", int'(busy), 0);
        check("abort done", int'(done), 0);
        check("abort digit_on", int'(digit_on), 0);
        #1;
        reset_n = 1'b1;
        repeat (20) @(posedge vga_clk);
        #1;
        check("abort no late done", int'(done), 0);
        check("abort stays idle", int'(busy), 0);
        scan("aborted", 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
